// File: rtl/i2c_pkg.sv
// Definitions shared by the I2C slave and master: FSM state encoding and
// the general-call address.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2c_state_t;

    localparam logic [6:0] GCALL_ADDR = 7'h00;

endpackage

// File: rtl/i2c_bus_mon.sv
// Synchronizes SCL/SDA into clk and flags SCL edges plus START/STOP.
// All outputs derive from the synchronized copies only.
module i2c_bus_mon (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;
    logic       scl_s;

    // Preset to 1 (idle bus) so reset release never fakes an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s    = scl_sync[1];
    assign sda_s    = sda_sync[1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// Oversampled I2C target, no clock stretching. Define I2C_SLAVE_GCALL_EN to
// accept general-call writes to address 7'h00.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | bus free or reset seen; wait for START
// ADDR     | shift in 7-bit address + R/W
// ADDR_ACK | drive ACK for the address, then branch on R/W
// WR_DATA  | shift in a write byte from the master
// WR_ACK   | drive ACK for the received byte
// RD_DATA  | shift out a read byte on SDA
// RD_ACK   | sample master ACK/NACK
// IGNORE   | not addressed (or NACKed); stay off the bus until START/STOP
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR  = 7'h50,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       pushout,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       selected
);

    i2c_state_t state, state_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [7:0] shift, shift_nx;
    logic       rw, rw_nx;
    logic       sda_oe, sda_oe_nx;
    logic [7:0] data_out_nx;
    logic       pushout_nx, tx_ready_nx, busy_nx, selected_nx;

    logic       scl_rise, scl_fall, start, stop, sda_s;
    logic [7:0] shift_in;
    logic [7:0] load_byte;
    logic       addr_hit;

    i2c_bus_mon u_bus_mon (
        .clk      (clk),
        .rst      (rst),
        .scl      (SCL),
        .sda      (SDA),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_s    (sda_s)
    );

    assign SDA       = sda_oe ? 1'b0 : 1'bz;
    assign shift_in  = {shift[6:0], sda_s};
    assign load_byte = tx_valid ? tx_data : IDLE_BYTE;

`ifdef I2C_SLAVE_GCALL_EN
    assign addr_hit = (shift_in[7:1] == SLV_ADDR) ||
                      ((shift_in[7:1] == GCALL_ADDR) && !shift_in[0]);
`else
    assign addr_hit = (shift_in[7:1] == SLV_ADDR);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= 3'd7;
            shift    <= 8'h00;
            rw       <= 1'b0;
            sda_oe   <= 1'b0;
            data_out <= 8'h00;
            pushout  <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
            selected <= 1'b0;
        end else begin
            state    <= state_nx;
            bit_cnt  <= bit_cnt_nx;
            shift    <= shift_nx;
            rw       <= rw_nx;
            sda_oe   <= sda_oe_nx;
            data_out <= data_out_nx;
            pushout  <= pushout_nx;
            tx_ready <= tx_ready_nx;
            busy     <= busy_nx;
            selected <= selected_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        shift_nx    = shift;
        rw_nx       = rw;
        sda_oe_nx   = sda_oe;
        data_out_nx = data_out;
        pushout_nx  = 1'b0;
        tx_ready_nx = 1'b0;
        busy_nx     = busy;
        selected_nx = selected;

        if (stop) begin
            state_nx    = IDLE;
            sda_oe_nx   = 1'b0;
            busy_nx     = 1'b0;
            selected_nx = 1'b0;
        end else if (start) begin
            state_nx    = ADDR;
            bit_cnt_nx  = 3'd7;
            sda_oe_nx   = 1'b0;
            busy_nx     = 1'b1;
            selected_nx = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shift_nx   = shift_in;
                    bit_cnt_nx = bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) begin
                        if (addr_hit) begin
                            state_nx    = ADDR_ACK;
                            rw_nx       = shift_in[0];
                            selected_nx = 1'b1;
                        end else begin
                            state_nx = IGNORE;
                        end
                    end
                end
                // First fall ends bit 8 and starts the ACK; second fall ends it
                ADDR_ACK, WR_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_nx = 1'b1;
                    end else begin
                        bit_cnt_nx = 3'd7;
                        if (state == ADDR_ACK && rw) begin
                            state_nx    = RD_DATA;
                            shift_nx    = load_byte;
                            sda_oe_nx   = ~load_byte[7];
                            tx_ready_nx = tx_valid;
                        end else begin
                            state_nx  = WR_DATA;
                            sda_oe_nx = 1'b0;
                        end
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shift_nx   = shift_in;
                    bit_cnt_nx = bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) begin
                        data_out_nx = shift_in;
                        pushout_nx  = 1'b1;
                        state_nx    = WR_ACK;
                    end
                end
                RD_DATA: if (scl_fall) begin
                    if (bit_cnt == 3'd0) begin
                        sda_oe_nx = 1'b0;
                        state_nx  = RD_ACK;
                    end else begin
                        bit_cnt_nx = bit_cnt - 3'd1;
                        shift_nx   = {shift[6:0], 1'b0};
                        sda_oe_nx  = ~shift[6];
                    end
                end
                RD_ACK: begin
                    if (scl_rise && sda_s) begin
                        state_nx = IGNORE;
                    end else if (scl_fall) begin
                        state_nx    = RD_DATA;
                        bit_cnt_nx  = 3'd7;
                        shift_nx    = load_byte;
                        sda_oe_nx   = ~load_byte[7];
                        tx_ready_nx = tx_valid;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
